// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared 3-operand 8-bit adder.
// Each operation runs IDLE (grant) -> CALC (add) -> RESP (hold result until consumed).
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [8*N_REQ-1:0]   req_c,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_sum,
    output logic [1:0]           resp_carry,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [7:0]     r_a;
    logic [7:0]     r_b;
    logic [7:0]     r_c;
    logic [9:0]     r_sum;

    logic           w_any;
    logic [IDW-1:0] w_grant;
    logic [7:0]     w_a;
    logic [7:0]     w_b;
    logic [7:0]     w_c;
    logic [IDW-1:0] w_next_ptr;
    logic           w_in_resp;
    int             w_dist;
    int             w_best;

    // Winner is the valid requester with the smallest upward distance from r_rr_ptr.
    always_comb begin
        w_any   = |req_valid;
        w_grant = '0;
        w_a     = '0;
        w_b     = '0;
        w_c     = '0;
        w_dist  = 0;
        w_best  = N_REQ;
        for (int j = 0; j < N_REQ; j++) begin
            w_dist = j - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_REQ;
            end
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = IDW'(j);
                w_a     = req_a[8*j +: 8];
                w_b     = req_b[8*j +: 8];
                w_c     = req_c[8*j +: 8];
            end
        end
    end

    // Reset gating keeps the strobe low while held in reset even though state reads as IDLE.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_next_ptr = (int'(r_id) == N_REQ - 1) ? '0 : r_id + IDW'(1);
    assign w_in_resp  = (r_state == S_RESP);
    assign resp_valid = w_in_resp;
    assign resp_sum   = w_in_resp ? r_sum[7:0] : 8'd0;
    assign resp_carry = w_in_resp ? r_sum[9:8] : 2'd0;
    assign resp_id    = w_in_resp ? r_id : '0;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_sum    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_c     <= w_c;
                        r_id    <= w_grant;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_sum   <= {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c};
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] req_c;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_sum;
    logic [1:0]  resp_carry;
    logic [1:0]  resp_id;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_id(resp_id),
        .busy(busy)
    );

    // Model: first valid index at or above the pointer, wrapping.
    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Drives one request through to its handshake and reports what it saw; it does not judge.
    task automatic txn(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input int stall,
                       output logic [3:0] rdy0, output logic [3:0] rdy1, output logic rv1,
                       output logic rv2, output logic [7:0] sum, output logic [1:0] carry,
                       output logic [1:0] id, output logic rv_end, output logic [7:0] sum_end,
                       output logic busy_end);
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b; req_c = c; resp_ready = (stall == 0);
        #1 rdy0 = req_ready;
        @(negedge clk);
        req_valid = '0;
        #1 rdy1 = req_ready; rv1 = resp_valid;
        @(negedge clk);
        #1 rv2 = resp_valid; sum = resp_sum; carry = resp_carry; id = resp_id;
        repeat (stall) @(negedge clk);
        #1 rv_end = resp_valid; sum_end = resp_sum;
        resp_ready = 1'b1;
        @(negedge clk);
        #1 busy_end = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF; req_a = '1; req_b = '1; req_c = '1; resp_ready = 1'b1;
        #3;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        checks++; if ({resp_carry, resp_sum} !== 10'd0) begin failures++; $display("FAIL reset_sum got=%h exp=000", {resp_carry, resp_sum}); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", resp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        apply_reset();
        #1;
        checks++; if (req_ready !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_quiet ready=%b busy=%b exp=0000/0", req_ready, busy); end
    endtask

    task automatic test_single();
        logic [3:0] r0, r1; logic v1, v2, ve, be; logic [7:0] s, se; logic [1:0] cy, id;
        int g;
        g = model_grant(4'b0010);
        txn(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r0, r1, v1, v2, s, cy, id, ve, se, be);
        m_ptr = (g + 1) % 4;
        checks++; if (r0 !== 4'b0010) begin failures++; $display("FAIL single_ready got=%b exp=0010", r0); end
        checks++; if (r1 !== 4'b0 || v1 !== 1'b0) begin failures++; $display("FAIL single_calc ready=%b valid=%b exp=0000/0", r1, v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", v2); end
        checks++; if (s !== 8'hFD || cy !== 2'b10) begin failures++; $display("FAIL single_sum got=%h/%b exp=fd/10", s, cy); end
        checks++; if (id !== 2'd1) begin failures++; $display("FAIL single_id got=%0d exp=1", id); end
        checks++; if (be !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", be); end
    endtask

    task automatic test_round_robin();
        int ids[5]; int sums[5]; int at[5]; int n; int g;
        apply_reset();
        n = 0;
        req_a = {8'd3, 8'd2, 8'd1, 8'd0}; req_b = '0; req_c = '0;
        resp_ready = 1'b1; req_valid = 4'hF;
        for (int cyc = 0; cyc < 30 && n < 5; cyc++) begin
            @(negedge clk); #1;
            if (resp_valid) begin
                ids[n] = int'(resp_id); sums[n] = int'(resp_sum); at[n] = cyc; n++;
            end
        end
        req_valid = '0;
        @(negedge clk);
        checks++; if (n !== 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", n); end
        for (int i = 0; i < n; i++) begin
            g = model_grant(4'hF);
            m_ptr = (g + 1) % 4;
            checks++; if (ids[i] !== g || sums[i] !== g) begin failures++; $display("FAIL rr_seq[%0d] id=%0d sum=%0d exp=%0d", i, ids[i], sums[i], g); end
            if (i > 0) begin
                checks++; if (at[i] - at[i-1] !== 3) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", i, at[i] - at[i-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int g; int bad;
        bad = 0;
        g = model_grant(4'b0001);
        @(negedge clk);
        req_valid = 4'b0001; req_a = 32'd10; req_b = 32'd20; req_c = 32'd30; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            if (resp_valid !== 1'b1 || resp_sum !== 8'd60 || resp_carry !== 2'd0 ||
                req_ready !== 4'b0 || resp_id !== 2'(g)) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        req_valid = '0; resp_ready = 1'b1;
        @(negedge clk); #1;
        m_ptr = (g + 1) % 4;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release valid=%b busy=%b exp=0/0", resp_valid, busy); end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] r0, r1; logic v1, v2, ve, be; logic [7:0] s, se; logic [1:0] cy, id;
        logic [3:0] vecs[3]; int g;
        vecs[0] = 4'b0100; vecs[1] = 4'b0001; vecs[2] = 4'b0101;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            g = model_grant(vecs[i]);
            txn(vecs[i], 32'h0403_0201, 32'h0, 32'h0, 0, r0, r1, v1, v2, s, cy, id, ve, se, be);
            m_ptr = (g + 1) % 4;
            checks++; if (r0 !== (4'b0001 << g) || id !== 2'(g) || s !== 8'(g + 1)) begin
                failures++; $display("FAIL wrap[%0d] ready=%b id=%0d sum=%0d exp_grant=%0d", i, r0, id, s, g);
            end
        end
        checks++; if (m_ptr !== 3) begin failures++; $display("FAIL wrap_model_ptr got=%0d exp=3", m_ptr); end
    endtask

    task automatic test_boundary();
        logic [3:0] r0, r1; logic v1, v2, ve, be; logic [7:0] s, se; logic [1:0] cy, id;
        txn(4'b1111, 32'h0, 32'h0, 32'h0, 0, r0, r1, v1, v2, s, cy, id, ve, se, be);
        m_ptr = (model_grant(4'b1111) + 1) % 4;
        checks++; if (s !== 8'd0 || cy !== 2'd0) begin failures++; $display("FAIL zero_sum got=%h/%b exp=00/00", s, cy); end
        txn(4'b1111, 32'h8080_8080, 32'h8080_8080, 32'h0, 0, r0, r1, v1, v2, s, cy, id, ve, se, be);
        m_ptr = (model_grant(4'b1111) + 1) % 4;
        checks++; if (s !== 8'd0 || cy !== 2'b01) begin failures++; $display("FAIL carry_sum got=%h/%b exp=00/01", s, cy); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] r0, r1; logic v1, v2, ve, be; logic [7:0] s, se; logic [1:0] cy, id;
        int seen;
        seen = 0;
        @(negedge clk);
        req_valid = 4'b0010; req_a = '1; req_b = '1; req_c = '1; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0 ||
                      resp_sum !== 8'd0 || resp_carry !== 2'd0 || resp_id !== 2'd0) begin
            failures++; $display("FAIL midrst_outputs busy=%b valid=%b ready=%b sum=%h carry=%b id=%0d exp=all0",
                                 busy, resp_valid, req_ready, resp_sum, resp_carry, resp_id);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
        txn(4'b1000, 32'h0900_0000, 32'h0100_0000, 32'h0, 0, r0, r1, v1, v2, s, cy, id, ve, se, be);
        m_ptr = 0;
        checks++; if (r0 !== 4'b1000 || id !== 2'd3 || s !== 8'd10 || v2 !== 1'b1) begin
            failures++; $display("FAIL midrst_next ready=%b id=%0d sum=%0d valid=%b exp=1000/3/10/1", r0, id, s, v2);
        end
    endtask

    task automatic test_random();
        logic [3:0] r0, r1; logic v1, v2, ve, be; logic [7:0] s, se; logic [1:0] cy, id;
        logic [3:0] v; logic [31:0] a, b, c; int st, g, tot;
        for (int i = 0; i < 25; i++) begin
            v = 4'($urandom_range(1, 15));
            a = $urandom; b = $urandom; c = $urandom;
            st = $urandom_range(0, 3);
            g = model_grant(v);
            tot = int'(a[8*g +: 8]) + int'(b[8*g +: 8]) + int'(c[8*g +: 8]);
            txn(v, a, b, c, st, r0, r1, v1, v2, s, cy, id, ve, se, be);
            m_ptr = (g + 1) % 4;
            checks++; if (r0 !== (4'b0001 << g) || id !== 2'(g)) begin
                failures++; $display("FAIL rand_grant[%0d] ready=%b id=%0d exp=%0d", i, r0, id, g);
            end
            checks++; if (v2 !== 1'b1 || s !== 8'(tot % 256) || cy !== 2'(tot / 256)) begin
                failures++; $display("FAIL rand_sum[%0d] valid=%b got=%h/%b exp=%h/%b", i, v2, s, cy, 8'(tot % 256), 2'(tot / 256));
            end
            checks++; if (ve !== 1'b1 || se !== 8'(tot % 256) || v1 !== 1'b0 || be !== 1'b0) begin
                failures++; $display("FAIL rand_hold[%0d] valid_end=%b sum_end=%h calc_valid=%b busy_end=%b", i, ve, se, v1, be);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
